// File: rtl/pool_pkg.sv
// pool_pkg: shared types and helpers for the pool result writer.
// Holds the writer FSM state encoding, the bus address width and the
// burst address calculation used when issuing write bursts.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } wr_state_t;

    localparam int ADDR_W = 28;

    // Byte address of burst 'burst' in vector 'vec': base + vec*ch*4 + burst*bl*4, mod 2^ADDR_W.
    // The 32-bit intermediate may wrap, but its low ADDR_W bits are still the modular result.
    function automatic logic [ADDR_W-1:0] burst_addr(
        input logic [ADDR_W-1:0] base,
        input logic [15:0]       vec,
        input logic [15:0]       burst,
        input logic [15:0]       ch,
        input logic [15:0]       bl
    );
        logic [31:0] sum_v;
        sum_v = 32'(base) + (32'(vec) * 32'(ch) * 32'd4) + (32'(burst) * 32'(bl) * 32'd4);
        return sum_v[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pool_vec_buf.sv
// pool_vec_buf: two-entry ping-pong buffer for pooled result vectors.
// A push is accepted only when an entry is free at that edge; a pop frees
// the head entry. The head entry can be read one WIDTH-bit word at a time.
module pool_vec_buf
    import pool_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CHANNEL_SIZE = 64,
    localparam int IDX_W       = (CHANNEL_SIZE > 1) ? $clog2(CHANNEL_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [CHANNEL_SIZE*WIDTH-1:0] push_data,
    input  logic                          pop,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic                          full,
    output logic                          empty,
    output logic [1:0]                    count,
    output logic [WIDTH-1:0]              rd_word
);

    logic [CHANNEL_SIZE*WIDTH-1:0] data_r [2];
    logic [1:0]                    valid_r;
    logic                          wr_ptr_r;
    logic                          rd_ptr_r;

    assign full    = valid_r[0] & valid_r[1];
    assign empty   = ~(valid_r[0] | valid_r[1]);
    assign count   = {valid_r[0] & valid_r[1], valid_r[0] ^ valid_r[1]};
    assign rd_word = data_r[rd_ptr_r][rd_idx*WIDTH +: WIDTH];

    // Entry storage, valid flags and ping-pong pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_r[i] <= '0;
            end
            valid_r  <= 2'b00;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (push && !full) begin
                data_r[wr_ptr_r]  <= push_data;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop && !empty) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ~rd_ptr_r;
            end
        end
    end

endmodule

// File: rtl/pool_result_writer.sv
// pool_result_writer: buffers pooled result vectors and writes each one out
// as CHANNEL_SIZE/BURST_LEN fixed-length bursts on the shared write bus.
// Optional feature macro: POOL_WR_PERF_EN adds saturating stall counters
// stall_aw_cnt / stall_w_cnt (cleared by reset or an accepted base_en).
module pool_result_writer
    import pool_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CHANNEL_SIZE = 64,
    parameter int BURST_LEN    = 16,
    parameter int AP_ID        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNEL_SIZE*WIDTH-1:0] result,
    input  logic                          result_en,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic                          base_en,
    output logic                          busy,
    output logic                          overflow,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [3:0]                    awlen,
    output logic [3:0]                    awuser_id,
    output logic                          awuser_ap,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [WIDTH-1:0]              wdata,
    output logic [WIDTH/8-1:0]            wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    output logic                          wlast
`ifdef POOL_WR_PERF_EN
    ,
    output logic [31:0]                   stall_aw_cnt,
    output logic [31:0]                   stall_w_cnt
`endif
);

    localparam int NUM_BURSTS = CHANNEL_SIZE / BURST_LEN;
    localparam int IDX_W      = (CHANNEL_SIZE > 1) ? $clog2(CHANNEL_SIZE) : 1;
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    wr_state_t            state_r, state_nx_s;
    logic [BURST_W-1:0]   burst_r, burst_nx_s;
    logic [BEAT_W-1:0]    beat_r, beat_nx_s;
    logic [15:0]          vec_cnt_r, vec_cnt_nx_s;
    logic [ADDR_W-1:0]    base_r;
    logic                 pop_s, push_ok_s, base_ld_s, busy_nx_s;
    logic                 buf_full_s, buf_empty_s;
    logic [1:0]           buf_cnt_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic [WIDTH-1:0]     buf_word_s;

    logic                 busy_r, overflow_r, awvalid_r, wvalid_r, wlast_r, awuser_ap_r;
    logic [ADDR_W-1:0]    awaddr_r;
    logic [3:0]           awlen_r, awuser_id_r;
    logic [WIDTH-1:0]     wdata_r;
    logic [WIDTH/8-1:0]   wstrb_r;

    assign push_ok_s = result_en && !buf_full_s;
    assign base_ld_s = base_en && (state_r == IDLE) && buf_empty_s;
    // Word fetched for the beat about to be presented, so wdata can be registered.
    assign rd_idx_s  = IDX_W'(burst_nx_s) * IDX_W'(BURST_LEN) + IDX_W'(beat_nx_s);
    // Buffer occupancy after this edge: a push into a full buffer is dropped.
    assign busy_nx_s = (state_nx_s != IDLE) || push_ok_s || (buf_cnt_s == 2'd2) ||
                       ((buf_cnt_s == 2'd1) && !pop_s);

    pool_vec_buf #(
        .WIDTH        (WIDTH),
        .CHANNEL_SIZE (CHANNEL_SIZE)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok_s),
        .push_data (result),
        .pop       (pop_s),
        .rd_idx    (rd_idx_s),
        .full      (buf_full_s),
        .empty     (buf_empty_s),
        .count     (buf_cnt_s),
        .rd_word   (buf_word_s)
    );

    // Next-state logic: address phase, data beats, burst/vector sequencing.
    always_comb begin
        state_nx_s   = state_r;
        burst_nx_s   = burst_r;
        beat_nx_s    = beat_r;
        vec_cnt_nx_s = vec_cnt_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!buf_empty_s) begin
                    state_nx_s = AW;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            AW: begin
                if (awvalid_r && awready) begin
                    state_nx_s = W;
                end else begin
                    state_nx_s = AW;
                end
            end
            W: begin
                if (wvalid_r && wready) begin
                    if (beat_r == LAST_BEAT) begin
                        beat_nx_s = '0;
                        if (burst_r != LAST_BURST) begin
                            burst_nx_s = burst_r + 1'b1;
                            state_nx_s = AW;
                        end else begin
                            burst_nx_s   = '0;
                            pop_s        = 1'b1;
                            vec_cnt_nx_s = vec_cnt_r + 16'd1;
                            state_nx_s   = buf_full_s ? AW : IDLE;
                        end
                    end else begin
                        beat_nx_s = beat_r + 1'b1;
                    end
                end else begin
                    state_nx_s = W;
                end
            end
            default: begin
                state_nx_s = IDLE;
                burst_nx_s = '0;
                beat_nx_s  = '0;
            end
        endcase
    end

    // FSM state, burst/beat position, vector counter, base address and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            burst_r    <= '0;
            beat_r     <= '0;
            vec_cnt_r  <= 16'd0;
            base_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            burst_r   <= burst_nx_s;
            beat_r    <= beat_nx_s;
            vec_cnt_r <= base_ld_s ? 16'd0 : vec_cnt_nx_s;
            if (base_ld_s) begin
                base_r <= base_addr;
            end
            if (base_ld_s) begin
                overflow_r <= 1'b0;
            end else if (result_en && buf_full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Registered bus outputs, loaded from the next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_r   <= 1'b0;
            awaddr_r    <= '0;
            wvalid_r    <= 1'b0;
            wlast_r     <= 1'b0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            busy_r      <= 1'b0;
            awlen_r     <= 4'd0;
            awuser_id_r <= 4'd0;
            awuser_ap_r <= 1'b0;
        end else begin
            awvalid_r <= (state_nx_s == AW);
            if (state_nx_s == AW) begin
                awaddr_r <= burst_addr(base_r, vec_cnt_nx_s, 16'(burst_nx_s),
                                       16'(CHANNEL_SIZE), 16'(BURST_LEN));
            end
            wvalid_r    <= (state_nx_s == W);
            wlast_r     <= (state_nx_s == W) && (beat_nx_s == LAST_BEAT);
            wdata_r     <= (state_nx_s == W) ? buf_word_s : '0;
            wstrb_r     <= (state_nx_s == W) ? {(WIDTH/8){1'b1}} : '0;
            busy_r      <= busy_nx_s;
            awlen_r     <= 4'(BURST_LEN - 1);
            awuser_id_r <= 4'(AP_ID);
            awuser_ap_r <= 1'b1;
        end
    end

    assign busy      = busy_r;
    assign overflow  = overflow_r;
    assign awaddr    = awaddr_r;
    assign awlen     = awlen_r;
    assign awuser_id = awuser_id_r;
    assign awuser_ap = awuser_ap_r;
    assign awvalid   = awvalid_r;
    assign wdata     = wdata_r;
    assign wstrb     = wstrb_r;
    assign wvalid    = wvalid_r;
    assign wlast     = wlast_r;

`ifdef POOL_WR_PERF_EN
    logic [31:0] stall_aw_cnt_r, stall_w_cnt_r;

    // Saturating counts of cycles where address or data is offered but not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_aw_cnt_r <= 32'd0;
            stall_w_cnt_r  <= 32'd0;
        end else if (base_ld_s) begin
            stall_aw_cnt_r <= 32'd0;
            stall_w_cnt_r  <= 32'd0;
        end else begin
            if (awvalid_r && !awready && (stall_aw_cnt_r != 32'hFFFF_FFFF)) begin
                stall_aw_cnt_r <= stall_aw_cnt_r + 32'd1;
            end
            if (wvalid_r && !wready && (stall_w_cnt_r != 32'hFFFF_FFFF)) begin
                stall_w_cnt_r <= stall_w_cnt_r + 32'd1;
            end
        end
    end

    assign stall_aw_cnt = stall_aw_cnt_r;
    assign stall_w_cnt  = stall_w_cnt_r;
`endif

endmodule

// File: tb/tb_pool_result_writer.sv
// tb_pool_result_writer: directed self-checking bench for pool_result_writer.
// A bus monitor records address/data handshakes and flags held values that
// change before acceptance; the main sequence compares against hand-built
// expectations. Stall counter steps run when POOL_WR_PERF_EN is defined.
module tb_pool_result_writer;
    import pool_pkg::*;

    localparam int WIDTH = 32;
    localparam int CH    = 64;
    localparam int BL    = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [CH*WIDTH-1:0]    result;
    logic                   result_en;
    logic [ADDR_W-1:0]      base_addr;
    logic                   base_en;
    logic                   busy, overflow, awuser_ap, awvalid, awready;
    logic [ADDR_W-1:0]      awaddr;
    logic [3:0]             awlen, awuser_id;
    logic [WIDTH-1:0]       wdata;
    logic [WIDTH/8-1:0]     wstrb;
    logic                   wvalid, wready, wlast;
`ifdef POOL_WR_PERF_EN
    logic [31:0]            stall_aw_cnt, stall_w_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int stable_viol = 0;
    int proto_viol = 0;
    int outstanding = 0;
    logic              prev_aw_pend = 1'b0;
    logic              prev_w_pend = 1'b0;
    logic [ADDR_W-1:0] prev_awaddr = '0;
    logic [WIDTH:0]    prev_w = '0;
    logic [ADDR_W-1:0] aw_q[$];
    logic [WIDTH:0]    w_q[$];

    pool_result_writer #(
        .WIDTH(WIDTH), .CHANNEL_SIZE(CH), .BURST_LEN(BL), .AP_ID(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .result_en(result_en),
        .base_addr(base_addr), .base_en(base_en), .busy(busy), .overflow(overflow),
        .awaddr(awaddr), .awlen(awlen), .awuser_id(awuser_id), .awuser_ap(awuser_ap),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .wlast(wlast)
`ifdef POOL_WR_PERF_EN
        , .stall_aw_cnt(stall_aw_cnt), .stall_w_cnt(stall_w_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    // Bus monitor: handshakes, hold stability, ordering of data after address.
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_aw_pend <= 1'b0;
            prev_w_pend  <= 1'b0;
            outstanding  <= 0;
        end else begin
            stable_viol <= stable_viol
                + int'(prev_aw_pend && (awvalid !== 1'b1 || awaddr !== prev_awaddr))
                + int'(prev_w_pend && (wvalid !== 1'b1 || {wlast, wdata} !== prev_w));
            proto_viol <= proto_viol
                + int'(wvalid && outstanding == 0)
                + int'(awvalid && awready && outstanding != 0);
            if (awvalid && awready) aw_q.push_back(awaddr);
            if (wvalid && wready) w_q.push_back({wlast, wdata});
            outstanding  <= outstanding + int'(awvalid && awready) - int'(wvalid && wready && wlast);
            prev_aw_pend <= awvalid && !awready;
            prev_awaddr  <= awaddr;
            prev_w_pend  <= wvalid && !wready;
            prev_w       <= {wlast, wdata};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_vec(input int off);
        for (int k = 0; k < CH; k++) result[k*WIDTH +: WIDTH] = 32'(k + off);
    endtask

    task automatic load_base(input logic [ADDR_W-1:0] a);
        @(negedge clk); base_en = 1'b1; base_addr = a;
        @(negedge clk); base_en = 1'b0;
    endtask

    task automatic pulse_vec(input int off);
        @(negedge clk); drive_vec(off); result_en = 1'b1;
        @(negedge clk); result_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Compare recorded bursts with the expected addresses and channel words.
    task automatic check_run(input string tag, input int nvec, input logic [ADDR_W-1:0] base,
                             input int off0, input int off1);
        logic [ADDR_W-1:0] exp_a;
        logic [WIDTH:0]    exp_w;
        int                off;
        chk({tag, "_aw_count"}, 64'(aw_q.size()), 64'(nvec * 4));
        chk({tag, "_w_count"}, 64'(w_q.size()), 64'(nvec * CH));
        for (int v = 0; v < nvec; v++) begin
            for (int b = 0; b < 4; b++) begin
                if (v * 4 + b < aw_q.size()) begin
                    exp_a = base + 28'(v * 256 + b * 64);
                    chk({tag, "_awaddr"}, 64'(aw_q[v * 4 + b]), 64'(exp_a));
                end
            end
            off = (v == 0) ? off0 : off1;
            for (int k = 0; k < CH; k++) begin
                if (v * CH + k < w_q.size()) begin
                    exp_w = {(k % BL) == (BL - 1), 32'(k + off)};
                    chk({tag, "_wlast_wdata"}, 64'(w_q[v * CH + k]), 64'(exp_w));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; result = '0; result_en = 1'b0; base_addr = '0; base_en = 1'b0;
        awready = 1'b0; wready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_wlast", 64'(wlast), 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_awlen", 64'(awlen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("const_awlen", 64'(awlen), 64'd15);
        chk("const_awuser_id", 64'(awuser_id), 64'd4);
        chk("const_awuser_ap", 64'(awuser_ap), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // T2: single vector, ready held high.
        awready = 1'b1; wready = 1'b1;
        load_base(28'h100);
        aw_q.delete(); w_q.delete();
        pulse_vec(0);
        chk("t2_busy_t1", 64'(busy), 64'd1);
        chk("t2_awvalid_t1", 64'(awvalid), 64'd0);
        @(negedge clk);
        chk("t2_awvalid_t2", 64'(awvalid), 64'd1);
        chk("t2_awaddr_first", 64'(awaddr), 64'h100);
        chk("t2_wvalid_t2", 64'(wvalid), 64'd0);
        wait_idle("t2", 400);
        check_run("t2", 1, 28'h100, 0, 0);
        chk("t2_aw_last_burst", 64'(aw_q.size() > 3 ? aw_q[3] : 28'hFFFFFFF), 64'h1C0);

        // T3: random backpressure on both channels.
        load_base(28'h100);
        aw_q.delete(); w_q.delete();
        pulse_vec(0);
        begin
            int n = 0;
            while (busy !== 1'b0 && n < 3000) begin
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
        end
        awready = 1'b1; wready = 1'b1;
        chk("t3_idle", 64'(busy), 64'd0);
        check_run("t3", 1, 28'h100, 0, 0);
        chk("t3_stable_viol", 64'(stable_viol), 64'd0);

        // T4: three back-to-back strobes with the address channel stalled.
        load_base(28'h100);
        awready = 1'b0;
        aw_q.delete(); w_q.delete();
        @(negedge clk); drive_vec(0); result_en = 1'b1;
        @(negedge clk); drive_vec(100);
        chk("t4_no_ovf_1", 64'(overflow), 64'd0);
        @(negedge clk); drive_vec(200);
        chk("t4_no_ovf_2", 64'(overflow), 64'd0);
        @(negedge clk); result_en = 1'b0;
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_awvalid_held", 64'(awvalid), 64'd1);
        repeat (3) @(negedge clk);
        chk("t4_awaddr_held", 64'(awaddr), 64'h100);
        awready = 1'b1;
        wait_idle("t4", 600);
        check_run("t4", 2, 28'h100, 0, 100);
        chk("t4_second_vec_addr", 64'(aw_q.size() > 4 ? aw_q[4] : 28'hFFFFFFF), 64'h200);
        chk("t4_overflow_sticky", 64'(overflow), 64'd1);
        load_base(28'h100);
        chk("t4_overflow_cleared", 64'(overflow), 64'd0);

        // T5: address wrap at 2^28.
        load_base(28'hFFFFFC0);
        aw_q.delete(); w_q.delete();
        @(negedge clk); drive_vec(0); result_en = 1'b1;
        @(negedge clk); drive_vec(7);
        @(negedge clk); result_en = 1'b0;
        wait_idle("t5", 600);
        check_run("t5", 2, 28'hFFFFFC0, 0, 7);
        chk("t5_wrap_burst1", 64'(aw_q.size() > 1 ? aw_q[1] : 28'hFFFFFFF), 64'h0000000);
        chk("t5_wrap_vec2", 64'(aw_q.size() > 4 ? aw_q[4] : 28'hFFFFFFF), 64'h00000C0);
        chk("t5_proto_viol", 64'(proto_viol), 64'd0);

        // T1: reset in the middle of a burst.
        pulse_vec(0);
        repeat (8) @(negedge clk);
        chk("t1_wvalid_before", 64'(wvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_wvalid", 64'(wvalid), 64'd0);
        chk("t1_rst_wdata", 64'(wdata), 64'd0);
        chk("t1_rst_awaddr", 64'(awaddr), 64'd0);
        chk("t1_rst_busy", 64'(busy), 64'd0);
        chk("t1_rst_wstrb", 64'(wstrb), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        aw_q.delete(); w_q.delete();
        repeat (4) @(negedge clk);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_no_new_aw", 64'(aw_q.size()), 64'd0);
        chk("t1_awvalid_after", 64'(awvalid), 64'd0);

`ifdef POOL_WR_PERF_EN
        // T6: data-channel stall count.
        load_base(28'h100);
        pulse_vec(0);
        begin
            int n = 0;
            while (wvalid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_wvalid_seen", 64'(wvalid), 64'd1);
        wready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_stall_w_5", 64'(stall_w_cnt), 64'd5);
        wready = 1'b1;
        wait_idle("t6", 400);
        chk("t6_stall_w_final", 64'(stall_w_cnt), 64'd5);
        chk("t6_stall_aw", 64'(stall_aw_cnt), 64'd0);
        load_base(28'h100);
        chk("t6_stall_w_cleared", 64'(stall_w_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
